// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencing controller.
// Optional feature macro: MIPS_CTRL_TRAP_EN (adds the HALT state and trap output).
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef MIPS_CTRL_TRAP_EN
        , S_HALT = 3'd5
`endif
    } state_e;

    // Operation class handed to the ALU decoder; NONE yields an all-zero alu_ctl.
    typedef enum logic [1:0] {
        ALU_NONE  = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2,
        ALU_FUNCT = 2'd3
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;

    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Unified instruction/data memory handshake between controller and memory.
interface mips_mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
    modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_alu_dec.sv
// Maps an ALU operation class plus the R-type funct field onto alu_ctl.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  alu_class_e  cls,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_ctl
);

    // Class/funct decode; unknown funct falls back to add.
    always_comb begin
        alu_ctl = ALU_CTL_AND;
        case (cls)
            ALU_ADD: alu_ctl = ALU_CTL_ADD;
            ALU_SUB: alu_ctl = ALU_CTL_SUB;
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_CTL_ADD;
                    FN_SUB:  alu_ctl = ALU_CTL_SUB;
                    FN_AND:  alu_ctl = ALU_CTL_AND;
                    FN_OR:   alu_ctl = ALU_CTL_OR;
                    FN_SLT:  alu_ctl = ALU_CTL_SLT;
                    default: alu_ctl = ALU_CTL_ADD;
                endcase
            end
            default: alu_ctl = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: FSM, datapath control decode and retire counter.
// Optional feature macro: MIPS_CTRL_TRAP_EN (illegal opcode halts and raises trap).
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    mips_mc_ctrl_if.master   mem,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctl,
    output logic [1:0]       pc_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_retired
`ifdef MIPS_CTRL_TRAP_EN
    , output logic           trap
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    alu_class_e       alu_cls_s;
    logic             mem_req_s, mem_we_s, ir_we_s, pc_we_s, reg_we_s, retire_s;

    mips_alu_dec u_alu_dec (
        .cls     (alu_cls_s),
        .funct   (funct),
        .alu_ctl (alu_ctl)
    );

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, bumped as an instruction leaves its final state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (retire_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Next-state and control decode; everything defaults to 0 / hold.
    always_comb begin
        state_d    = state_q;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        mem.i_or_d = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        reg_we_s   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_cls_s  = ALU_NONE;
        pc_src     = PC_SRC_ALU;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_cls_s = ALU_ADD;
                if (mem.mem_ready) begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = SRC_B_IMM_SH;
                alu_cls_s = ALU_ADD;
                if (opcode == OP_J) begin
                    pc_we_s  = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else if (op_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
`ifdef MIPS_CTRL_TRAP_EN
                    state_d  = S_HALT;
`else
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_cls_s = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = SRC_B_IMM;
                        alu_cls_s = ALU_ADD;
                        state_d   = S_MEM;
                    end
                    OP_ADDI: begin
                        alu_src_b = SRC_B_IMM;
                        alu_cls_s = ALU_ADD;
                        state_d   = S_WB;
                    end
                    OP_BEQ: begin
                        alu_cls_s = ALU_SUB;
                        pc_src    = PC_SRC_ALUOUT;
                        pc_we_s   = zero;
                        retire_s  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req_s  = 1'b1;
                mem.i_or_d = 1'b1;
                mem_we_s   = (opcode == OP_SW);
                if (mem.mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_we_s   = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MIPS_CTRL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing is written while held in reset.
    assign mem.mem_req   = mem_req_s & reset;
    assign mem.mem_we    = mem_we_s  & reset;
    assign ir_we         = ir_we_s   & reset;
    assign pc_we         = pc_we_s   & reset;
    assign reg_we        = reg_we_s  & reset;
    assign state         = state_q;
    assign instr_retired = cnt_q;
`ifdef MIPS_CTRL_TRAP_EN
    assign trap          = (state_q == S_HALT);
`endif

endmodule
